dtmf_peak_detector: RTL and testbench
=====================================

DTMF_PEAK_DETECTOR -- requirements
Module: dtmf_peak_detector

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed width of each bin component.
REQ-002 SHALL have parameter NUM_BINS, default 64, bins per frame.
REQ-003 SHALL have parameters LOW_LO/LOW_HI, defaults 19/25, inclusive low-group bin range.
REQ-004 SHALL have parameters HIGH_LO/HIGH_HI, defaults 32/43, inclusive high-group bin range.
REQ-005 SHALL have parameter TWIST_SH, default 3, permitted group ratio as a power of two (8x).
REQ-006 SHALL derive IDX_W = clog2(NUM_BINS) and MAG_W = DATA_W+1.
REQ-007 SHALL have port clock, input, 1 bit, single clock; all state on rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port enable, input, 1 bit; low aborts and holds the block idle.
REQ-010 SHALL have ports bin_valid (in, 1) and bin_sof (in, 1); sof with valid marks bin 0.
REQ-011 SHALL have ports bin_re and bin_im, input, DATA_W each, signed two's complement.
REQ-012 SHALL have port min_mag, input, MAG_W bits, detection threshold.
REQ-013 SHALL have outputs result_valid (1), low_idx and high_idx (IDX_W), low_mag and high_mag (MAG_W), tone_detected (1), frame_err (1).

Function
REQ-014 SHALL compute mag = max(|re|,|im|) + (min(|re|,|im|) >> 1), unsigned MAG_W bits, registered one cycle; |-2^(DATA_W-1)| = 2^(DATA_W-1) with no overflow.
REQ-015 SHALL use FSM states IDLE, ACCUM, REPORT.
REQ-016 IDLE: valid bins without sof SHALL be ignored; valid with sof -> ACCUM, bin index 0, group maxima cleared.
REQ-017 ACCUM: bin index SHALL increment by one per valid bin only; bin_valid-low gaps of any length allowed.
REQ-018 SHALL update a group maximum only when mag is strictly greater, so on ties the lowest index wins; bins outside both ranges SHALL be ignored.
REQ-019 With no qualifying bin in a group, its mag SHALL be 0 and idx SHALL be the group's LO bound.
REQ-020 After bin NUM_BINS-1 is accepted -> REPORT; result_valid SHALL pulse for exactly one cycle, 2 cycles after that bin is sampled; next cycle -> IDLE.
REQ-021 Outputs idx/mag/tone_detected SHALL hold their values until the next result_valid.
REQ-022 tone_detected SHALL be 1 iff both mags >= min_mag AND low_mag <= (high_mag << TWIST_SH) AND high_mag <= (low_mag << TWIST_SH), using MAG_W+TWIST_SH-bit compares.
REQ-023 Valid sof while in ACCUM SHALL pulse frame_err for one cycle, discard the partial frame, and restart at bin 0 with that bin, with no result_valid.
REQ-024 enable low SHALL return the FSM to IDLE within one cycle with no result_valid or frame_err; bins arriving in REPORT SHALL be ignored.

Reset
REQ-025 reset_n low SHALL asynchronously force state IDLE and zero all counters, maxima, the mag pipeline and every output.
REQ-026 Reset deassertion mid-frame SHALL require a fresh sof before any result.

Structure
REQ-027 Package dtmf_pkg SHALL hold the FSM state enum, parameter defaults, and clog2 helper.
REQ-028 Magnitude approximation SHALL be sub-module dtmf_mag_approx (combinational abs/max/min plus output register).

Verification
REQ-029 Frame 64 bins, bin 21 = (40,30), bin 36 = (-50,10), others (1,1), min_mag 20 -> result_valid 2 cycles after bin 63; low_idx 21 mag 55, high_idx 36 mag 55, tone_detected 1.
REQ-030 Equal maxima mag 30 at bins 20 and 23 -> low_idx 20.
REQ-031 low mag 100, high mag 10, TWIST_SH 3 -> tone_detected 0 (100 > 80); high mag 13 -> 1.
REQ-032 sof re-asserted at bin 30 -> frame_err pulse, no result; full following frame reports normally.
REQ-033 bin_re = -128, bin_im = -128 -> mag 192, no wrap; random bin_valid gaps yield results identical to the gapless run.
REQ-034 reset_n low at bin 40, and separately enable low at bin 40 -> no result_valid until the next complete sof frame; all outputs 0 after reset.

Source files
------------

// File: rtl/dtmf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dtmf_pkg : shared FSM type, parameter defaults and clog2 helper  (rev 1.0)
// ---------------------------------------------------------------------------
package dtmf_pkg;

   localparam int DTMF_DATA_W   = 8;
   localparam int DTMF_NUM_BINS = 64;
   localparam int DTMF_LOW_LO   = 19;
   localparam int DTMF_LOW_HI   = 25;
   localparam int DTMF_HIGH_LO  = 32;
   localparam int DTMF_HIGH_HI  = 43;
   localparam int DTMF_TWIST_SH = 3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   function automatic int dtmf_clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dtmf_mag_approx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dtmf_mag_approx : registered max(|re|,|im|) + min(|re|,|im|)/2   (rev 1.0)
// ---------------------------------------------------------------------------
module dtmf_mag_approx
   import dtmf_pkg::*;
#(
   parameter  int DATA_W = DTMF_DATA_W,
   localparam int MAG_W  = DATA_W + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] i_re,
   input  logic signed [DATA_W-1:0] i_im,
   output logic        [MAG_W-1:0]  o_mag
);

   // One extra bit so that |most-negative| is representable.
   logic signed [MAG_W-1:0] w_re_ext;
   logic signed [MAG_W-1:0] w_im_ext;
   logic        [MAG_W-1:0] w_abs_re;
   logic        [MAG_W-1:0] w_abs_im;
   logic        [MAG_W-1:0] w_max;
   logic        [MAG_W-1:0] w_min;
   logic        [MAG_W-1:0] w_mag;

   assign w_re_ext = MAG_W'(i_re);
   assign w_im_ext = MAG_W'(i_im);
   assign w_abs_re = w_re_ext[MAG_W-1] ? $unsigned(-w_re_ext) : $unsigned(w_re_ext);
   assign w_abs_im = w_im_ext[MAG_W-1] ? $unsigned(-w_im_ext) : $unsigned(w_im_ext);
   assign w_max    = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
   assign w_min    = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
   assign w_mag    = w_max + (w_min >> 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_mag <= '0;
      end else begin
         o_mag <= w_mag;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dtmf_peak_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dtmf_peak_detector : per-frame low/high group peak search with twist check (rev 1.0)
// ---------------------------------------------------------------------------
module dtmf_peak_detector
   import dtmf_pkg::*;
#(
   parameter  int DATA_W   = DTMF_DATA_W,
   parameter  int NUM_BINS = DTMF_NUM_BINS,
   parameter  int LOW_LO   = DTMF_LOW_LO,
   parameter  int LOW_HI   = DTMF_LOW_HI,
   parameter  int HIGH_LO  = DTMF_HIGH_LO,
   parameter  int HIGH_HI  = DTMF_HIGH_HI,
   parameter  int TWIST_SH = DTMF_TWIST_SH,
   localparam int IDX_W    = dtmf_clog2(NUM_BINS),
   localparam int MAG_W    = DATA_W + 1
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     bin_valid,
   input  logic                     bin_sof,
   input  logic signed [DATA_W-1:0] bin_re,
   input  logic signed [DATA_W-1:0] bin_im,
   input  logic        [MAG_W-1:0]  min_mag,
   output logic                     result_valid,
   output logic        [IDX_W-1:0]  low_idx,
   output logic        [IDX_W-1:0]  high_idx,
   output logic        [MAG_W-1:0]  low_mag,
   output logic        [MAG_W-1:0]  high_mag,
   output logic                     tone_detected,
   output logic                     frame_err
);

   localparam int               TW_W      = MAG_W + TWIST_SH;
   localparam logic [IDX_W-1:0] C_LOW_LO  = IDX_W'(LOW_LO);
   localparam logic [IDX_W-1:0] C_LOW_HI  = IDX_W'(LOW_HI);
   localparam logic [IDX_W-1:0] C_HIGH_LO = IDX_W'(HIGH_LO);
   localparam logic [IDX_W-1:0] C_HIGH_HI = IDX_W'(HIGH_HI);
   localparam logic [IDX_W-1:0] C_LAST    = IDX_W'(NUM_BINS - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic             r_p_valid;
   logic             r_p_sof;
   logic [MAG_W-1:0] w_mag;
   logic [IDX_W-1:0] r_cnt;
   logic [IDX_W-1:0] w_bin_idx;
   logic [IDX_W-1:0] r_low_idx;
   logic [IDX_W-1:0] r_high_idx;
   logic [IDX_W-1:0] w_low_idx;
   logic [IDX_W-1:0] w_high_idx;
   logic [MAG_W-1:0] r_low_mag;
   logic [MAG_W-1:0] r_high_mag;
   logic [MAG_W-1:0] w_low_mag;
   logic [MAG_W-1:0] w_high_mag;
   logic             w_take;
   logic             w_report;
   logic             w_frame_err;
   logic             w_tone;
   logic [TW_W-1:0]  w_low_shl;
   logic [TW_W-1:0]  w_high_shl;

   dtmf_mag_approx #(
      .DATA_W (DATA_W)
   ) u_mag (
      .clk   (clock),
      .rst_n (reset_n),
      .i_re  (bin_re),
      .i_im  (bin_im),
      .o_mag (w_mag)
   );

   // valid/sof travel alongside the registered magnitude
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_p_valid <= 1'b0;
         r_p_sof   <= 1'b0;
      end else begin
         r_p_valid <= bin_valid & enable;
         r_p_sof   <= bin_sof;
      end
   end

   assign w_take    = enable && r_p_valid &&
                      ((r_state == S_ACCUM) || ((r_state == S_IDLE) && r_p_sof));
   assign w_bin_idx = r_p_sof ? '0 : r_cnt;

   always_comb begin
      w_low_idx  = r_low_idx;
      w_low_mag  = r_low_mag;
      w_high_idx = r_high_idx;
      w_high_mag = r_high_mag;
      if (r_p_sof) begin
         w_low_idx  = C_LOW_LO;
         w_low_mag  = '0;
         w_high_idx = C_HIGH_LO;
         w_high_mag = '0;
      end
      // strict compare keeps the lowest index on ties
      if ((w_bin_idx >= C_LOW_LO) && (w_bin_idx <= C_LOW_HI) && (w_mag > w_low_mag)) begin
         w_low_idx = w_bin_idx;
         w_low_mag = w_mag;
      end
      if ((w_bin_idx >= C_HIGH_LO) && (w_bin_idx <= C_HIGH_HI) && (w_mag > w_high_mag)) begin
         w_high_idx = w_bin_idx;
         w_high_mag = w_mag;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_report     = 1'b0;
      w_frame_err  = 1'b0;
      if (!enable) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_take) w_next_state = S_ACCUM;
            end
            S_ACCUM: begin
               if (w_take) begin
                  if (r_p_sof)                  w_frame_err  = 1'b1;
                  else if (w_bin_idx == C_LAST) w_next_state = S_REPORT;
               end
            end
            S_REPORT: begin
               w_report     = 1'b1;
               w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= '0;
         r_low_idx  <= '0;
         r_low_mag  <= '0;
         r_high_idx <= '0;
         r_high_mag <= '0;
      end else if (w_take) begin
         r_cnt      <= w_bin_idx + IDX_W'(1);
         r_low_idx  <= w_low_idx;
         r_low_mag  <= w_low_mag;
         r_high_idx <= w_high_idx;
         r_high_mag <= w_high_mag;
      end
   end

   assign w_low_shl  = TW_W'(r_low_mag) << TWIST_SH;
   assign w_high_shl = TW_W'(r_high_mag) << TWIST_SH;
   assign w_tone     = (r_low_mag >= min_mag) && (r_high_mag >= min_mag) &&
                       (TW_W'(r_low_mag) <= w_high_shl) && (TW_W'(r_high_mag) <= w_low_shl);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         result_valid  <= 1'b0;
         frame_err     <= 1'b0;
         low_idx       <= '0;
         low_mag       <= '0;
         high_idx      <= '0;
         high_mag      <= '0;
         tone_detected <= 1'b0;
      end else begin
         result_valid <= w_report;
         frame_err    <= w_frame_err;
         if (w_report) begin
            low_idx       <= r_low_idx;
            low_mag       <= r_low_mag;
            high_idx      <= r_high_idx;
            high_mag      <= r_high_mag;
            tone_detected <= w_tone;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dtmf_peak_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dtmf_peak_detector : directed self-checking bench for dtmf_peak_detector (rev 1.0)
// ---------------------------------------------------------------------------
module tb_dtmf_peak_detector;

   localparam int DATA_W   = 8;
   localparam int NUM_BINS = 64;
   localparam int IDX_W    = 6;
   localparam int MAG_W    = 9;

   logic                     clock     = 1'b0;
   logic                     reset_n   = 1'b0;
   logic                     enable    = 1'b0;
   logic                     bin_valid = 1'b0;
   logic                     bin_sof   = 1'b0;
   logic signed [DATA_W-1:0] bin_re    = '0;
   logic signed [DATA_W-1:0] bin_im    = '0;
   logic        [MAG_W-1:0]  min_mag   = '0;
   logic                     result_valid;
   logic        [IDX_W-1:0]  low_idx;
   logic        [IDX_W-1:0]  high_idx;
   logic        [MAG_W-1:0]  low_mag;
   logic        [MAG_W-1:0]  high_mag;
   logic                     tone_detected;
   logic                     frame_err;

   int n_checks = 0;
   int n_fail   = 0;
   int rv_cnt   = 0;
   int fe_cnt   = 0;
   int fr_re[NUM_BINS];
   int fr_im[NUM_BINS];

   dtmf_peak_detector u_dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable        (enable),
      .bin_valid     (bin_valid),
      .bin_sof       (bin_sof),
      .bin_re        (bin_re),
      .bin_im        (bin_im),
      .min_mag       (min_mag),
      .result_valid  (result_valid),
      .low_idx       (low_idx),
      .high_idx      (high_idx),
      .low_mag       (low_mag),
      .high_mag      (high_mag),
      .tone_detected (tone_detected),
      .frame_err     (frame_err)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (result_valid) rv_cnt++;
      if (frame_err)    fe_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      check({tag, ".result_valid"}, int'(result_valid), 0);
      check({tag, ".low_idx"},      int'(low_idx), 0);
      check({tag, ".high_idx"},     int'(high_idx), 0);
      check({tag, ".low_mag"},      int'(low_mag), 0);
      check({tag, ".high_mag"},     int'(high_mag), 0);
      check({tag, ".tone"},         int'(tone_detected), 0);
      check({tag, ".frame_err"},    int'(frame_err), 0);
   endtask

   task automatic fill(input int re, input int im);
      for (int i = 0; i < NUM_BINS; i++) begin
         fr_re[i] = re;
         fr_im[i] = im;
      end
   endtask

   task automatic send_bins(input int first, input int last, input bit sof_first, input bit gaps);
      for (int i = first; i <= last; i++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin
               @(negedge clock);
               bin_valid = 1'b0;
               bin_sof   = 1'b0;
               bin_re    = 8'sd127;
               bin_im    = 8'sd127;
            end
         end
         @(negedge clock);
         bin_valid = 1'b1;
         bin_sof   = sof_first && (i == first);
         bin_re    = DATA_W'(fr_re[i]);
         bin_im    = DATA_W'(fr_im[i]);
      end
   endtask

   task automatic wait_result(output int lat);
      lat = -1;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clock);
         bin_valid = 1'b0;
         bin_sof   = 1'b0;
         if (result_valid && lat < 0) lat = k;
         if (lat >= 0) break;
      end
   endtask

   task automatic run_frame(input string tag, input bit gaps, input int e_li, input int e_lm,
                            input int e_hi, input int e_hm, input int e_t);
      int lat;
      int rv0;
      rv0 = rv_cnt;
      send_bins(0, NUM_BINS - 1, 1'b1, gaps);
      wait_result(lat);
      check({tag, ".latency"},  lat, 2);
      check({tag, ".low_idx"},  int'(low_idx), e_li);
      check({tag, ".low_mag"},  int'(low_mag), e_lm);
      check({tag, ".high_idx"}, int'(high_idx), e_hi);
      check({tag, ".high_mag"}, int'(high_mag), e_hm);
      check({tag, ".tone"},     int'(tone_detected), e_t);
      repeat (4) @(posedge clock);
      check({tag, ".rv_pulses"}, rv_cnt - rv0, 1);
   endtask

   task automatic load_frame_a();
      fill(1, 1);
      fr_re[21] = 40;  fr_im[21] = 30;
      fr_re[36] = -50; fr_im[36] = 10;
      // large bins just outside both groups must be ignored
      fr_re[18] = 127; fr_im[18] = 127;
      fr_re[26] = 127; fr_im[26] = 127;
      fr_re[31] = 127; fr_im[31] = 127;
      fr_re[44] = 127; fr_im[44] = 127;
   endtask

   initial begin
      int rv0;
      int fe0;

      repeat (3) @(negedge clock);
      chk_zero("reset");
      reset_n = 1'b1;
      enable  = 1'b1;
      repeat (2) @(negedge clock);

      load_frame_a();
      min_mag = 9'd20;
      run_frame("frameA", 1'b0, 21, 55, 36, 55, 1);

      min_mag = 9'd55;
      run_frame("minmag_eq", 1'b0, 21, 55, 36, 55, 1);
      min_mag = 9'd56;
      run_frame("minmag_gt", 1'b0, 21, 55, 36, 55, 0);

      fill(1, 1);
      fr_re[20] = 30; fr_im[20] = 0;
      fr_re[23] = 0;  fr_im[23] = -30;
      min_mag = 9'd20;
      run_frame("tie", 1'b0, 20, 30, 32, 1, 0);

      fill(0, 0);
      fr_re[40] = 60;
      run_frame("empty_low", 1'b0, 19, 0, 40, 60, 0);

      fill(0, 0);
      min_mag = 9'd5;
      fr_re[22] = 100; fr_re[35] = 10;
      run_frame("twist_100_10", 1'b0, 22, 100, 35, 10, 0);
      fr_re[35] = 13;
      run_frame("twist_100_13", 1'b0, 22, 100, 35, 13, 1);
      fr_re[22] = 80; fr_re[35] = 10;
      run_frame("twist_80_10", 1'b0, 22, 80, 35, 10, 1);
      fr_re[22] = 10; fr_re[35] = 81;
      run_frame("twist_10_81", 1'b0, 22, 10, 35, 81, 0);

      fill(1, 1);
      fr_re[19] = -128; fr_im[19] = -128;
      fr_re[43] = -128; fr_im[43] = -128;
      min_mag = 9'd20;
      run_frame("neg_full", 1'b0, 19, 192, 43, 192, 1);
      run_frame("neg_gaps", 1'b1, 19, 192, 43, 192, 1);

      // partial frame carries a bigger low peak that must be discarded
      fe0 = fe_cnt;
      rv0 = rv_cnt;
      fill(1, 1);
      fr_re[21] = 100;
      send_bins(0, 29, 1'b1, 1'b0);
      load_frame_a();
      run_frame("restart", 1'b0, 21, 55, 36, 55, 1);
      check("restart.frame_err_pulses", fe_cnt - fe0, 1);
      check("restart.total_rv", rv_cnt - rv0, 1);

      rv0 = rv_cnt;
      send_bins(0, 40, 1'b1, 1'b0);
      @(negedge clock);
      bin_valid = 1'b0;
      reset_n   = 1'b0;
      #1;
      chk_zero("midrst");
      @(negedge clock);
      reset_n = 1'b1;
      send_bins(41, NUM_BINS - 1, 1'b0, 1'b0);
      @(negedge clock);
      bin_valid = 1'b0;
      repeat (6) @(posedge clock);
      check("midrst.no_result", rv_cnt - rv0, 0);
      run_frame("after_rst", 1'b0, 21, 55, 36, 55, 1);

      fill(1, 1);
      fr_re[20] = 30; fr_re[23] = 30;
      rv0 = rv_cnt;
      fe0 = fe_cnt;
      send_bins(0, 40, 1'b1, 1'b0);
      @(negedge clock);
      bin_valid = 1'b0;
      enable    = 1'b0;
      @(negedge clock);
      enable = 1'b1;
      send_bins(41, NUM_BINS - 1, 1'b0, 1'b0);
      @(negedge clock);
      bin_valid = 1'b0;
      repeat (6) @(posedge clock);
      check("enable.no_result", rv_cnt - rv0, 0);
      check("enable.no_frame_err", fe_cnt - fe0, 0);
      check("enable.hold_low_idx", int'(low_idx), 21);
      run_frame("after_en", 1'b0, 20, 30, 32, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
